// File: rtl/dmem_responder.sv
// Data-memory responder between the EX/MEM request and the RAM port, with ERROR retry,
// latency watchdog and halt quiescing. Optional statistics counters behind DMEM_STATS_EN.
module dmem_responder #(
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        dfault,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [15:0] fault_count
`endif
);

  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam int RW = $clog2(MAX_RETRY) + 1;
  // Forced completion fires in the cycle whose running wait count reaches TIMEOUT-1.
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 2);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [1:0]    RAM_ACCESS = 2'd2;
  localparam logic [1:0]    RAM_ERROR  = 2'd3;
  localparam logic [31:0]   FAULT_WORD = 32'hBAD1BAD1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RETRY, S_HALTED} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] waitCnt_q, waitCnt_d;
  logic [RW-1:0] retryCnt_q, retryCnt_d;
  logic          haltPend_q, haltPend_d;
  logic          dfault_q;
  logic [31:0]   dmemload_q, ramaddr_q, ramstore_q;

  logic req, isWrite, inService, accessHit, timeoutHit, retryExhaust, forced;
  state_t doneState;

  always_comb begin
    req       = dmemREN | dmemWEN;
    isWrite   = dmemWEN;
    inService = nRST && (state_q == S_IDLE || state_q == S_WAIT) && req;
    accessHit = inService && (ramstate == RAM_ACCESS);
    timeoutHit   = nRST && state_q == S_WAIT && req && ramstate != RAM_ACCESS
                   && waitCnt_q >= WAIT_LAST;
    retryExhaust = nRST && state_q == S_WAIT && req && ramstate == RAM_ERROR
                   && retryCnt_q >= RETRY_LAST;
    forced    = timeoutHit | retryExhaust;
    dhit      = accessHit | forced;
    ramREN    = inService & ~isWrite;
    ramWEN    = inService & isWrite;
    ramaddr   = inService ? dmemaddr  : ramaddr_q;
    ramstore  = inService ? dmemstore : ramstore_q;
    if (forced)                     dmemload = FAULT_WORD;
    else if (accessHit && !isWrite) dmemload = ramload;
    else                            dmemload = dmemload_q;
    dfault    = dfault_q;
  end

  // A halt seen while an access is outstanding is remembered so completion lands in HALTED.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    retryCnt_d = retryCnt_q;
    haltPend_d = haltPend_q;
    doneState  = (halt || haltPend_q) ? S_HALTED : S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (dhit) begin
          state_d    = doneState;
          waitCnt_d  = '0;
          retryCnt_d = '0;
          haltPend_d = 1'b0;
        end else if (req) begin
          state_d    = S_WAIT;
          waitCnt_d  = WW'(1);
          retryCnt_d = '0;
          haltPend_d = halt;
        end else if (halt) begin
          state_d = S_HALTED;
        end
      end
      S_WAIT: begin
        if (!req || dhit) begin
          state_d    = req ? doneState : S_IDLE;
          waitCnt_d  = '0;
          retryCnt_d = '0;
          haltPend_d = 1'b0;
        end else begin
          haltPend_d = haltPend_q | halt;
          if (waitCnt_q != '1) waitCnt_d = waitCnt_q + WW'(1);
          if (ramstate == RAM_ERROR) begin
            state_d    = S_RETRY;
            retryCnt_d = retryCnt_q + RW'(1);
          end
        end
      end
      S_RETRY: begin
        if (!req) begin
          state_d    = S_IDLE;
          waitCnt_d  = '0;
          retryCnt_d = '0;
          haltPend_d = 1'b0;
        end else begin
          state_d    = S_WAIT;
          waitCnt_d  = WW'(1);
          haltPend_d = haltPend_q | halt;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      waitCnt_q  <= '0;
      retryCnt_q <= '0;
      haltPend_q <= 1'b0;
      dfault_q   <= 1'b0;
      dmemload_q <= '0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      retryCnt_q <= retryCnt_d;
      haltPend_q <= haltPend_d;
      dfault_q   <= dfault_q | forced;
      dmemload_q <= dmemload;
      ramaddr_q  <= ramaddr;
      ramstore_q <= ramstore;
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_count    <= '0;
      wr_count    <= '0;
      fault_count <= '0;
    end else begin
      if (dhit && !isWrite) rd_count <= rd_count + 32'd1;
      if (dhit && isWrite)  wr_count <= wr_count + 32'd1;
      if (forced)           fault_count <= fault_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: hits, waits, retries, timeout,
// halt quiescing and asynchronous reset.
module tb_dmem_responder;

  logic        CLK, nRST;
  logic        dmemREN, dmemWEN, halt;
  logic [31:0] dmemaddr, dmemstore, ramload;
  logic [1:0]  ramstate;
  logic        dhit, dfault, ramREN, ramWEN;
  logic [31:0] dmemload, ramaddr, ramstore;
`ifdef DMEM_STATS_EN
  logic [31:0] rd_count, wr_count;
  logic [15:0] fault_count;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  dmem_responder #(.TIMEOUT(64), .MAX_RETRY(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt), .dhit(dhit), .dmemload(dmemload), .dfault(dfault),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef DMEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .fault_count(fault_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic ren, input logic wen, input logic [31:0] addr,
                               input logic [31:0] store, input logic hlt,
                               input logic [1:0] rs, input logic [31:0] rl);
    @(negedge CLK);
    dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = store;
    halt = hlt; ramstate = rs; ramload = rl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    nRST = 1'b0; dmemREN = 0; dmemWEN = 0; halt = 0; ramstate = FREE;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b1; dmemREN = 1'b1; dmemWEN = 1'b0; halt = 1'b0;
    dmemaddr = 32'h44; dmemstore = 32'h55; ramstate = ACCESS; ramload = 32'h99;
    #1 nRST = 1'b0;
    #2;
    $display("[TB] reset checks");
    checkOutput("rst_dhit", dhit, 0);
    checkOutput("rst_ramREN", ramREN, 0);
    checkOutput("rst_ramaddr", ramaddr, 0);
    checkOutput("rst_dmemload", dmemload, 0);
    checkOutput("rst_dfault", dfault, 0);
    @(negedge CLK);
    dmemREN = 0; ramstate = FREE; nRST = 1'b1;

    // T1: single-cycle load hit, data held afterwards
    applyStimulus(1, 0, 32'h10, 0, 0, ACCESS, 32'h1234);
    checkOutput("t1_dhit", dhit, 1);
    checkOutput("t1_load", dmemload, 32'h1234);
    checkOutput("t1_ramREN", ramREN, 1);
    checkOutput("t1_ramaddr", ramaddr, 32'h10);
    applyStimulus(0, 0, 32'h0, 0, 0, FREE, 32'hFFFF);
    checkOutput("t1_dhit_after", dhit, 0);
    checkOutput("t1_load_held", dmemload, 32'h1234);
    checkOutput("t1_ramREN_off", ramREN, 0);
    checkOutput("t1_ramaddr_held", ramaddr, 32'h10);

    // back-to-back single-cycle hits
    applyStimulus(1, 0, 32'h20, 0, 0, ACCESS, 32'hA1);
    checkOutput("b2b_hit1", dhit, 1);
    checkOutput("b2b_load1", dmemload, 32'hA1);
    applyStimulus(1, 0, 32'h24, 0, 0, ACCESS, 32'hA2);
    checkOutput("b2b_hit2", dhit, 1);
    checkOutput("b2b_load2", dmemload, 32'hA2);

    // T2: store with three BUSY cycles then ACCESS
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 32'h40, 32'hCAFE, 0, (i == 4) ? ACCESS : BUSY, 32'h7);
      checkOutput("t2_ramWEN", ramWEN, 1);
      checkOutput("t2_ramREN", ramREN, 0);
      checkOutput("t2_dhit", dhit, (i == 4) ? 1 : 0);
    end
    checkOutput("t2_ramstore", ramstore, 32'hCAFE);
    checkOutput("t2_ramaddr", ramaddr, 32'h40);
    checkOutput("t2_load_held", dmemload, 32'hA2);
    applyStimulus(0, 0, 32'h0, 0, 0, FREE, 0);
    checkOutput("t2_dfault", dfault, 0);
    checkOutput("t2_dhit_after", dhit, 0);

    // both strobes requested: treated as a write
    applyStimulus(1, 1, 32'h50, 32'hBEEF, 0, ACCESS, 32'h3333);
    checkOutput("rw_ramWEN", ramWEN, 1);
    checkOutput("rw_ramREN", ramREN, 0);
    checkOutput("rw_dhit", dhit, 1);
    checkOutput("rw_load_held", dmemload, 32'hA2);

    // T3: ERROR forever -> three one-cycle gaps, then forced completion
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 0, 32'h80, 0, 0, ERROR, 32'h1);
      checkOutput("t3_ramREN", ramREN, (i == 3 || i == 5 || i == 7) ? 0 : 1);
      checkOutput("t3_dhit", dhit, (i == 8) ? 1 : 0);
    end
    checkOutput("t3_load", dmemload, BAD);
    applyStimulus(0, 0, 32'h0, 0, 0, FREE, 0);
    checkOutput("t3_dfault", dfault, 1);
    checkOutput("t3_load_held", dmemload, BAD);

    doReset();
    #1;
    checkOutput("t4_dfault_cleared", dfault, 0);

    // T4: BUSY forever -> watchdog completion in cycle 63
    for (int i = 1; i <= 63; i++) begin
      applyStimulus(1, 0, 32'h90, 0, 0, BUSY, 32'h2);
      checkOutput("t4_dhit", dhit, (i == 63) ? 1 : 0);
    end
    checkOutput("t4_load", dmemload, BAD);
    applyStimulus(1, 0, 32'h94, 0, 0, ACCESS, 32'h6666);
    checkOutput("t4_idle_hit", dhit, 1);
    checkOutput("t4_dfault", dfault, 1);
    checkOutput("t4_load_new", dmemload, 32'h6666);

    // T5: halt during a 3-cycle load
    applyStimulus(1, 0, 32'h100, 0, 0, BUSY, 0);
    checkOutput("t5_c1_dhit", dhit, 0);
    applyStimulus(1, 0, 32'h100, 0, 1, BUSY, 0);
    checkOutput("t5_c2_ramREN", ramREN, 1);
    checkOutput("t5_c2_dhit", dhit, 0);
    applyStimulus(1, 0, 32'h100, 0, 1, ACCESS, 32'h5555);
    checkOutput("t5_c3_dhit", dhit, 1);
    checkOutput("t5_c3_load", dmemload, 32'h5555);
    applyStimulus(1, 0, 32'h104, 0, 0, ACCESS, 32'h1111);
    checkOutput("t5_halted_ramREN", ramREN, 0);
    checkOutput("t5_halted_dhit", dhit, 0);
    checkOutput("t5_halted_load", dmemload, 32'h5555);
    applyStimulus(0, 1, 32'h108, 32'h9, 0, ACCESS, 0);
    checkOutput("t5_halted_ramWEN", ramWEN, 0);
    checkOutput("t5_halted_dhit2", dhit, 0);

    // T6: withdrawn request, then asynchronous reset mid-access
    doReset();
    applyStimulus(1, 0, 32'h200, 0, 0, ACCESS, 32'h7777);
    checkOutput("t6_pre_load", dmemload, 32'h7777);
    applyStimulus(1, 0, 32'h300, 0, 0, BUSY, 0);
    applyStimulus(1, 0, 32'h300, 0, 0, BUSY, 0);
    checkOutput("t6_busy_ramREN", ramREN, 1);
    applyStimulus(0, 0, 32'h300, 0, 0, ACCESS, 0);
    checkOutput("t6_drop_ramREN", ramREN, 0);
    checkOutput("t6_drop_dhit", dhit, 0);
    applyStimulus(1, 0, 32'h400, 0, 0, BUSY, 0);
    applyStimulus(1, 0, 32'h400, 0, 0, ACCESS, 32'h8888);
    checkOutput("t6_pre_rst_ramREN", ramREN, 1);
    nRST = 1'b0;
    #1;
    checkOutput("t6_rst_ramREN", ramREN, 0);
    checkOutput("t6_rst_dhit", dhit, 0);
    checkOutput("t6_rst_ramaddr", ramaddr, 0);
    checkOutput("t6_rst_load", dmemload, 0);
    checkOutput("t6_rst_dfault", dfault, 0);
    @(negedge CLK);
    dmemREN = 0; ramstate = FREE;
    nRST = 1'b1;
    #1;
    checkOutput("t6_after_dhit", dhit, 0);
    checkOutput("t6_after_load", dmemload, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
